ram_access_arbiter: RTL and testbench

Shares the single RAM port between the instruction-fetch requester and the data-access (load/store) requester of the control unit. It runs the RAM's MFA/MFC handshake on behalf of whichever requester wins arbitration, and returns the read data with a one-cycle acknowledge. It sits between the control-unit sequencing logic and the RAM model, replacing direct drive of ramMFA/ramRW/ramAddress/ramDataSize.

---
 rtl/ram_access_arbiter_pkg.sv | 27 ++
 rtl/ram_access_arbiter_rr_arb2.sv | 25 ++
 rtl/ram_access_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_access_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// Shared types for the RAM access arbiter: FSM states, requester IDs and
// RAM data-size codes, plus a small helper used by the round-robin pick.
package ram_access_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } arbState_t;

  typedef enum logic {
    REQ_DATA  = 1'b0,
    REQ_FETCH = 1'b1
  } reqId_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } dataSize_t;

  // The requester that did not win last time.
  function automatic logic otherReq(input logic id);
    return (id == REQ_DATA) ? REQ_FETCH : REQ_DATA;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_rr_arb2.sv
// Two-requester round-robin pick (combinational). The last-grant history
// lives in the parent; until the first grant after reset, data wins ties.
module rr_arb2
  import ram_access_arbiter_pkg::*;
(
  input  logic dataReq,
  input  logic fetchReq,
  input  logic lastGrant,
  input  logic historyValid,
  output logic grantValid,
  output logic grantId
);

  // Single pending requester wins; on a tie alternate away from the last winner.
  always_comb begin
    grantValid = dataReq | fetchReq;
    grantId    = REQ_DATA;
    if (dataReq && fetchReq) begin
      grantId = historyValid ? otherReq(lastGrant) : REQ_DATA;
    end else if (fetchReq) begin
      grantId = REQ_FETCH;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single RAM port between instruction fetch and data access,
// running the MFA/MFC handshake for the winner and returning a one-cycle ack.
// Optional feature: define RAM_TIMEOUT_EN to abort an access that sees no
// ramMFC within TIMEOUT cycles (ack plus busError); otherwise ACCESS waits forever.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifAck,
  output logic [DATA_W-1:0] ifData,
  input  logic              dReq,
  input  logic              dRW,
  input  logic [1:0]        dSize,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic              dAck,
  output logic [DATA_W-1:0] dRData,
  output logic              busError,
  output logic              ramMFA,
  output logic              ramRW,
  output logic [1:0]        ramDataSize,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramDataOut,
  input  logic [DATA_W-1:0] ramDataIn,
  input  logic              ramMFC
);

  arbState_t state;
  logic      lastGrant;
  logic      haveGranted;   // cleared by reset so data wins the first tie
  logic      grantOwner;    // requester currently holding the RAM port
  logic      grantValid;
  logic      grantId;

`ifdef RAM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] timeoutCount;
`else
  // TIMEOUT only matters when the watchdog is compiled in.
  assign busError = 1'b0 & (TIMEOUT != 0);
`endif

  rr_arb2 uArb (
    .dataReq      (dReq),
    .fetchReq     (ifReq),
    .lastGrant    (lastGrant),
    .historyValid (haveGranted),
    .grantValid   (grantValid),
    .grantId      (grantId)
  );

  // Arbitration FSM with registered RAM-side outputs and ack/data returns.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state       <= IDLE;
      lastGrant   <= REQ_DATA;
      haveGranted <= 1'b0;
      grantOwner  <= REQ_DATA;
      ramMFA      <= 1'b0;
      ramRW       <= 1'b0;
      ramDataSize <= 2'b00;
      ramAddress  <= '0;
      ramDataOut  <= '0;
      ifAck       <= 1'b0;
      dAck        <= 1'b0;
      ifData      <= '0;
      dRData      <= '0;
`ifdef RAM_TIMEOUT_EN
      busError     <= 1'b0;
      timeoutCount <= '0;
`endif
    end else begin
      ifAck <= 1'b0;
      dAck  <= 1'b0;
`ifdef RAM_TIMEOUT_EN
      busError <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grantValid) begin
            lastGrant   <= grantId;
            haveGranted <= 1'b1;
            grantOwner  <= grantId;
            ramMFA      <= 1'b1;
            state       <= ACCESS;
`ifdef RAM_TIMEOUT_EN
            timeoutCount <= '0;
`endif
            if (grantId == REQ_FETCH) begin
              ramRW       <= 1'b1;
              ramDataSize <= SZ_WORD;
              ramAddress  <= ifAddr;
              ramDataOut  <= '0;
            end else begin
              ramRW       <= dRW;
              ramDataSize <= dSize;
              ramAddress  <= dAddr;
              ramDataOut  <= dWData;
            end
          end
        end
        ACCESS: begin
          if (ramMFC) begin
            ramMFA <= 1'b0;
            state  <= RELEASE;
            if (grantOwner == REQ_FETCH) begin
              ifAck  <= 1'b1;
              ifData <= ramDataIn;
            end else begin
              dAck   <= 1'b1;
              dRData <= ramRW ? ramDataIn : '0;
            end
          end
`ifdef RAM_TIMEOUT_EN
          else if (timeoutCount == CNT_W'(TIMEOUT - 1)) begin
            ramMFA   <= 1'b0;
            state    <= RELEASE;
            busError <= 1'b1;
            if (grantOwner == REQ_FETCH) begin
              ifAck  <= 1'b1;
              ifData <= '0;
            end else begin
              dAck   <= 1'b1;
              dRData <= '0;
            end
          end else begin
            timeoutCount <= timeoutCount + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (!ramMFC) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: expected grants and acks are queued
// by the stimulus; a RAM model checks grants and a monitor checks acks.
module tb_ram_access_arbiter;

  logic        Clk = 1'b0;
  logic        reset;
  logic        ifReq;
  logic [8:0]  ifAddr;
  logic        ifAck;
  logic [31:0] ifData;
  logic        dReq;
  logic        dRW;
  logic [1:0]  dSize;
  logic [8:0]  dAddr;
  logic [31:0] dWData;
  logic        dAck;
  logic [31:0] dRData;
  logic        busError;
  logic        ramMFA;
  logic        ramRW;
  logic [1:0]  ramDataSize;
  logic [8:0]  ramAddress;
  logic [31:0] ramDataOut;
  logic [31:0] ramDataIn;
  logic        ramMFC;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] dout;
  } grantExp_t;

  typedef struct {
    logic        isFetch;
    logic [31:0] data;
    logic        berr;
  } ackExp_t;

  grantExp_t grantQ[$];
  ackExp_t   ackQ[$];

  // RAM model controls
  int  mfcDelay = 0;
  int  mfcHold = 0;
  logic ramStall = 1'b0;
  logic expectTimeout = 1'b0;
  int  phase = 0;
  int  cnt = 0;
  int  holdCnt = 0;
  int  mfaCycles = 0;
  logic prevAck = 1'b0;

  ram_access_arbiter dut (
    .Clk         (Clk),
    .reset       (reset),
    .ifReq       (ifReq),
    .ifAddr      (ifAddr),
    .ifAck       (ifAck),
    .ifData      (ifData),
    .dReq        (dReq),
    .dRW         (dRW),
    .dSize       (dSize),
    .dAddr       (dAddr),
    .dWData      (dWData),
    .dAck        (dAck),
    .dRData      (dRData),
    .busError    (busError),
    .ramMFA      (ramMFA),
    .ramRW       (ramRW),
    .ramDataSize (ramDataSize),
    .ramAddress  (ramAddress),
    .ramDataOut  (ramDataOut),
    .ramDataIn   (ramDataIn),
    .ramMFC      (ramMFC)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [31:0] memWord(input logic [8:0] a);
    if (a == 9'h004) return 32'h00221820;
    return {16'hC0DE, 7'b0, a};
  endfunction

  task automatic pushGrant(input logic rw, input logic [1:0] sz, input logic [8:0] a, input logic [31:0] d);
    grantExp_t g;
    g.rw = rw; g.size = sz; g.addr = a; g.dout = d;
    grantQ.push_back(g);
  endtask

  task automatic pushAck(input logic f, input logic [31:0] d, input logic be);
    ackExp_t e;
    e.isFetch = f; e.data = d; e.berr = be;
    ackQ.push_back(e);
  endtask

  task automatic fetchDrive(input logic [8:0] a);
    logic got;
    got = 1'b0;
    ifAddr = a;
    ifReq = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (ifAck) begin got = 1'b1; break; end
    end
    ifReq = 1'b0;
    if (!got) flag("fetchAckTimeout");
  endtask

  task automatic dataDrive(input logic rw, input logic [1:0] sz, input logic [8:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    dRW = rw; dSize = sz; dAddr = a; dWData = d;
    dReq = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (dAck) begin got = 1'b1; break; end
    end
    dReq = 1'b0;
    if (!got) flag("dataAckTimeout");
  endtask

  task automatic startGrant();
    grantExp_t g;
    check("mfcLowAtGrant", 32'(ramMFC), 32'd0);
    ramMFC = 1'b0;
    if (grantQ.size() == 0) begin
      flag("unexpectedGrant");
    end else begin
      g = grantQ.pop_front();
      check("grantRW", 32'(ramRW), 32'(g.rw));
      check("grantSize", 32'(ramDataSize), 32'(g.size));
      check("grantAddr", 32'(ramAddress), 32'(g.addr));
      check("grantDataOut", ramDataOut, g.dout);
      $display("grant rw=%0d size=%b addr=%h dout=%h", ramRW, ramDataSize, ramAddress, ramDataOut);
    end
    cnt = 0;
    mfaCycles = 0;
    phase = 1;
  endtask

  // RAM model: answers MFA with MFC after mfcDelay cycles, holds MFC mfcHold cycles past the ack.
  initial begin
    ramMFC = 1'b0;
    ramDataIn = 32'h0;
    forever begin
      @(posedge Clk);
      #1;
      if (reset) begin
        ramMFC = 1'b0;
        phase = 0;
      end else begin
        if ((phase == 0 || phase == 3) && ramMFA) begin
          startGrant();
        end else if (phase == 3) begin
          holdCnt++;
          if (holdCnt >= mfcHold) begin ramMFC = 1'b0; phase = 0; end
        end else if (phase == 2 && !ramMFA) begin
          holdCnt = 0;
          if (mfcHold == 0) begin ramMFC = 1'b0; phase = 0; end
          else phase = 3;
        end
        if (phase == 1) begin
          if (!ramMFA) begin
            if (expectTimeout) check("timeoutCycles", 32'(mfaCycles), 32'd15);
            else flag("mfaDroppedWithoutMfc");
            phase = 0;
          end else begin
            mfaCycles++;
            if (!ramStall && cnt >= mfcDelay) begin
              ramDataIn = memWord(ramAddress);
              ramMFC = 1'b1;
              phase = 2;
            end else begin
              cnt++;
            end
          end
        end
      end
    end
  end

  // Ack monitor: pops the scoreboard on every ack pulse.
  always @(negedge Clk) begin : monitor
    ackExp_t e;
    if (!reset) begin
      if (ifAck || dAck) begin
        check("ackOverlap", 32'(ifAck & dAck), 32'd0);
        check("ackWidth", 32'(prevAck), 32'd0);
        check("mfaLowAtAck", 32'(ramMFA), 32'd0);
        if (ackQ.size() == 0) begin
          flag("unexpectedAck");
        end else begin
          e = ackQ.pop_front();
          check("ackKind", 32'(ifAck), 32'(e.isFetch));
          check("ackData", ifAck ? ifData : dRData, e.data);
          check("ackBusError", 32'(busError), 32'(e.berr));
          $display("ack %s data=%h busError=%0d", ifAck ? "fetch" : "data", ifAck ? ifData : dRData, busError);
        end
      end else if (busError) begin
        check("busErrorWithoutAck", 32'(busError), 32'd0);
      end
    end
    prevAck <= ifAck | dAck;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ifReq = 1'b0; ifAddr = '0;
    dReq = 1'b0; dRW = 1'b0; dSize = 2'b00; dAddr = '0; dWData = '0;
    repeat (3) @(negedge Clk);
    check("rstMFA", 32'(ramMFA), 32'd0);
    check("rstRW", 32'(ramRW), 32'd0);
    check("rstSize", 32'(ramDataSize), 32'd0);
    check("rstAddr", 32'(ramAddress), 32'd0);
    check("rstDataOut", ramDataOut, 32'd0);
    check("rstIfAck", 32'(ifAck), 32'd0);
    check("rstDAck", 32'(dAck), 32'd0);
    check("rstBusError", 32'(busError), 32'd0);
    check("rstIfData", ifData, 32'd0);
    check("rstDRData", dRData, 32'd0);
    reset = 1'b0;
    @(negedge Clk);

    // single fetch, RAM answers 2 cycles after MFA
    mfcDelay = 2;
    pushGrant(1'b1, 2'b10, 9'h004, 32'h0);
    pushAck(1'b1, 32'h00221820, 1'b0);
    fetchDrive(9'h004);
    mfcDelay = 0;

    // byte store
    pushGrant(1'b0, 2'b00, 9'h010, 32'hA5);
    pushAck(1'b0, 32'h0, 1'b0);
    dataDrive(1'b0, 2'b00, 9'h010, 32'hA5);

    // halfword load
    pushGrant(1'b1, 2'b01, 9'h020, 32'h1234);
    pushAck(1'b0, 32'hC0DE0020, 1'b0);
    dataDrive(1'b1, 2'b01, 9'h020, 32'h1234);

    // slow RAM: MFC held 3 cycles after each ack; last grant was data so fetch wins
    mfcHold = 3;
    pushGrant(1'b1, 2'b10, 9'h008, 32'h0);
    pushAck(1'b1, 32'hC0DE0008, 1'b0);
    pushGrant(1'b0, 2'b10, 9'h030, 32'hCAFEF00D);
    pushAck(1'b0, 32'h0, 1'b0);
    fork
      fetchDrive(9'h008);
      dataDrive(1'b0, 2'b10, 9'h030, 32'hCAFEF00D);
    join
    repeat (6) @(negedge Clk);
    mfcHold = 0;

    // reset in the middle of an access
    ramStall = 1'b1;
    pushGrant(1'b1, 2'b10, 9'h040, 32'h0);
    dRW = 1'b1; dSize = 2'b10; dAddr = 9'h040; dWData = 32'h0;
    dReq = 1'b1;
    for (int i = 0; i < 20 && !ramMFA; i++) @(negedge Clk);
    check("midAccessMFA", 32'(ramMFA), 32'd1);
    repeat (2) @(negedge Clk);
    reset = 1'b1;
    @(posedge Clk);
    #1;
    check("resetDropsMFA", 32'(ramMFA), 32'd0);
    check("resetNoDAck", 32'(dAck), 32'd0);
    @(negedge Clk);
    dReq = 1'b0;
    @(negedge Clk);
    reset = 1'b0;
    ramStall = 1'b0;
    @(negedge Clk);

    // simultaneous requests after reset: data, fetch, data
    pushGrant(1'b1, 2'b10, 9'h044, 32'h0);
    pushAck(1'b0, 32'hC0DE0044, 1'b0);
    pushGrant(1'b1, 2'b10, 9'h00C, 32'h0);
    pushAck(1'b1, 32'hC0DE000C, 1'b0);
    pushGrant(1'b0, 2'b00, 9'h048, 32'h5A);
    pushAck(1'b0, 32'h0, 1'b0);
    fork
      begin
        dataDrive(1'b1, 2'b10, 9'h044, 32'h0);
        dataDrive(1'b0, 2'b00, 9'h048, 32'h5A);
      end
      fetchDrive(9'h00C);
    join

`ifdef RAM_TIMEOUT_EN
    // RAM never answers: abort after 15 ACCESS cycles
    repeat (4) @(negedge Clk);
    ramStall = 1'b1;
    expectTimeout = 1'b1;
    pushGrant(1'b1, 2'b10, 9'h050, 32'h0);
    pushAck(1'b0, 32'h0, 1'b1);
    dataDrive(1'b1, 2'b10, 9'h050, 32'h0);
    repeat (3) @(negedge Clk);
    ramStall = 1'b0;
    expectTimeout = 1'b0;
`endif

    repeat (8) @(negedge Clk);
    check("grantQueueDrained", 32'(grantQ.size()), 32'd0);
    check("ackQueueDrained", 32'(ackQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
